// File: rtl/accel_pkg.sv
// Shared constants and state encoding for the ADXL345 frame assembler.
package accel_pkg;

    localparam int ACCEL_FRAME_BYTES = 6;
    localparam int LAST_IDX          = ACCEL_FRAME_BYTES - 1;

    localparam logic [7:0] REG_DATAX0 = 8'h32;
    localparam logic [7:0] REG_DATAX1 = 8'h33;
    localparam logic [7:0] REG_DATAY0 = 8'h34;
    localparam logic [7:0] REG_DATAY1 = 8'h35;
    localparam logic [7:0] REG_DATAZ0 = 8'h36;
    localparam logic [7:0] REG_DATAZ1 = 8'h37;

    localparam int TILT_LEFT  = 0;
    localparam int TILT_RIGHT = 1;
    localparam int TILT_DOWN  = 2;
    localparam int TILT_UP    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } frame_state_e;

endpackage

// File: rtl/axis_block_avg.sv
// Block averager for one axis with a hysteresis tilt comparator on the average.
module axis_block_avg
    import accel_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int TILT_THRESH = 64,
    parameter int TILT_HYST   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid_i,
    input  logic signed [15:0] sample_i,
    output logic signed [15:0] avg_o,
    output logic               avg_valid_o,
    output logic               pos_o,
    output logic               neg_o
);

    localparam int AW   = 16 + AVG_LOG2;
    localparam int CW   = 18;
    localparam int CNTW = AVG_LOG2 + 1;
    localparam logic [CNTW-1:0]     CNT_LAST = CNTW'((1 << AVG_LOG2) - 1);
    localparam logic signed [CW-1:0] THR     = CW'(TILT_THRESH);
    localparam logic signed [CW-1:0] CLR     = CW'(TILT_THRESH - TILT_HYST);

    logic signed [AW-1:0] acc_q, acc_d, sum;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic signed [15:0]   avg_q, avg_d, avg_new;
    logic signed [CW-1:0] avg_ext;
    logic                 valid_q, valid_d;
    logic                 pos_q, pos_d, neg_q, neg_d;

    assign sum     = acc_q + AW'(sample_i);
    assign avg_new = 16'(sum >>> AVG_LOG2);
    assign avg_ext = CW'(avg_new);

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        valid_d = 1'b0;
        pos_d   = pos_q;
        neg_d   = neg_q;
        if (sample_valid_i) begin
            if (cnt_q == CNT_LAST) begin
                acc_d   = '0;
                cnt_d   = '0;
                avg_d   = avg_new;
                valid_d = 1'b1;
                // A sign flip past the threshold moves the flag straight across.
                if (avg_ext > THR) begin
                    pos_d = 1'b1;
                    neg_d = 1'b0;
                end else if (avg_ext < -THR) begin
                    pos_d = 1'b0;
                    neg_d = 1'b1;
                end else if (avg_ext < CLR && avg_ext > -CLR) begin
                    pos_d = 1'b0;
                    neg_d = 1'b0;
                end
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    assign avg_o       = avg_q;
    assign avg_valid_o = valid_q;
    assign pos_o       = pos_q;
    assign neg_o       = neg_q;

endmodule

// File: rtl/accel_frame_assembler.sv
// Assembles ADXL345 DATAX0..DATAZ1 byte bursts into X/Y/Z samples, averages X/Y, derives tilt.
//   state      | meaning
//   ST_IDLE    | waiting for a byte qualified by frame_start
//   ST_COLLECT | storing bytes 1..5 of the burst
//   ST_PUBLISH | raw_* and sample_valid presented; behaves like IDLE for new bytes
module accel_frame_assembler
    import accel_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int TILT_THRESH = 64,
    parameter int TILT_HYST   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    input  logic               frame_start,
    input  logic               frame_abort,
    output logic signed [15:0] raw_x,
    output logic signed [15:0] raw_y,
    output logic signed [15:0] raw_z,
    output logic               sample_valid,
    output logic signed [15:0] avg_x,
    output logic signed [15:0] avg_y,
    output logic               avg_valid,
    output logic [3:0]         tilt,
    output logic               frame_error,
    output logic [7:0]         frame_count
);

    localparam logic [2:0] IDX_LAST = 3'(LAST_IDX);

    frame_state_e              state_q, state_d;
    logic [2:0]                idx_q, idx_d;
    logic [LAST_IDX-1:0][7:0]  buf_q, buf_d;
    logic [15:0]               raw_x_q, raw_x_d, raw_y_q, raw_y_d, raw_z_q, raw_z_d;
    logic                      sv_q, sv_d, err_q, err_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      start_ok;
    logic                      x_pos, x_neg, y_pos, y_neg, avg_valid_x, avg_valid_y;

    assign start_ok = byte_valid && frame_start;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        raw_x_d = raw_x_q;
        raw_y_d = raw_y_q;
        raw_z_d = raw_z_q;
        sv_d    = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_COLLECT: begin
                if (frame_abort) begin
                    err_d   = 1'b1;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else if (start_ok) begin
                    err_d    = 1'b1;
                    buf_d[0] = byte_in;
                    idx_d    = 3'd1;
                end else if (byte_valid) begin
                    if (idx_q == IDX_LAST) begin
                        // Z1 goes straight into raw_z so sample_valid lands one clock later.
                        raw_x_d = {buf_q[1], buf_q[0]};
                        raw_y_d = {buf_q[3], buf_q[2]};
                        raw_z_d = {byte_in, buf_q[4]};
                        sv_d    = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        idx_d   = '0;
                        state_d = ST_PUBLISH;
                    end else begin
                        buf_d[idx_q] = byte_in;
                        idx_d        = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                if (start_ok) begin
                    buf_d[0] = byte_in;
                    idx_d    = 3'd1;
                    state_d  = ST_COLLECT;
                end else begin
                    err_d   = byte_valid;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            raw_x_q <= '0;
            raw_y_q <= '0;
            raw_z_q <= '0;
            sv_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            raw_x_q <= raw_x_d;
            raw_y_q <= raw_y_d;
            raw_z_q <= raw_z_d;
            sv_q    <= sv_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    axis_block_avg #(.AVG_LOG2(AVG_LOG2), .TILT_THRESH(TILT_THRESH), .TILT_HYST(TILT_HYST)) u_avg_x (
        .clk           (clk),
        .reset         (reset),
        .sample_valid_i(sv_q),
        .sample_i      (raw_x_q),
        .avg_o         (avg_x),
        .avg_valid_o   (avg_valid_x),
        .pos_o         (x_pos),
        .neg_o         (x_neg)
    );

    axis_block_avg #(.AVG_LOG2(AVG_LOG2), .TILT_THRESH(TILT_THRESH), .TILT_HYST(TILT_HYST)) u_avg_y (
        .clk           (clk),
        .reset         (reset),
        .sample_valid_i(sv_q),
        .sample_i      (raw_y_q),
        .avg_o         (avg_y),
        .avg_valid_o   (avg_valid_y),
        .pos_o         (y_pos),
        .neg_o         (y_neg)
    );

    always_comb begin
        tilt             = '0;
        tilt[TILT_LEFT]  = x_neg;
        tilt[TILT_RIGHT] = x_pos;
        tilt[TILT_DOWN]  = y_neg;
        tilt[TILT_UP]    = y_pos;
    end

    // Both axes share one sample stream, so their valid pulses coincide.
    assign avg_valid    = avg_valid_x && avg_valid_y;
    assign raw_x        = raw_x_q;
    assign raw_y        = raw_y_q;
    assign raw_z        = raw_z_q;
    assign sample_valid = sv_q;
    assign frame_error  = err_q;
    assign frame_count  = cnt_q;

endmodule

// File: tb/tb_accel_frame_assembler.sv
// Randomized bench for accel_frame_assembler against a queue-based frame/average model.
module tb_accel_frame_assembler;

    localparam int BLK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_abort = 1'b0;
    logic [15:0] raw_x, raw_y, raw_z, avg_x, avg_y;
    logic        sample_valid, avg_valid, frame_error;
    logic [3:0]  tilt;
    logic [7:0]  frame_count;

    int n_pass = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    accel_frame_assembler dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .frame_abort (frame_abort),
        .raw_x       (raw_x),
        .raw_y       (raw_y),
        .raw_z       (raw_z),
        .sample_valid(sample_valid),
        .avg_x       (avg_x),
        .avg_y       (avg_y),
        .avg_valid   (avg_valid),
        .tilt        (tilt),
        .frame_error (frame_error),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    bit          in_frame;
    logic [7:0]  part[$];
    int          blk_x[$], blk_y[$];
    logic [15:0] m_raw_x, m_raw_y, m_raw_z, m_avg_x, m_avg_y;
    logic        m_sv, m_av, m_err;
    logic [3:0]  m_tilt;
    logic [7:0]  m_cnt;

    function automatic int floor_avg(input int s[$]);
        int sum = 0;
        int q;
        foreach (s[i]) sum += s[i];
        q = sum / BLK;
        if ((sum % BLK) != 0 && sum < 0) q -= 1;
        return q;
    endfunction

    // returns {positive_flag, negative_flag}
    function automatic logic [1:0] tilt_upd(input int a, input logic [1:0] cur);
        int mag = (a < 0) ? -a : a;
        if (a > 64) return 2'b10;
        if (a < -64) return 2'b01;
        if (mag < 48) return 2'b00;
        return cur;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            in_frame = 0; part.delete(); blk_x.delete(); blk_y.delete();
            m_raw_x = 0; m_raw_y = 0; m_raw_z = 0; m_avg_x = 0; m_avg_y = 0;
            m_sv = 0; m_av = 0; m_err = 0; m_tilt = 0; m_cnt = 0;
        end else begin
            int ax, ay;
            m_av = 0;
            if (m_sv) begin
                blk_x.push_back(int'($signed(m_raw_x)));
                blk_y.push_back(int'($signed(m_raw_y)));
                if (blk_x.size() == BLK) begin
                    ax = floor_avg(blk_x);
                    ay = floor_avg(blk_y);
                    m_avg_x = 16'(ax);
                    m_avg_y = 16'(ay);
                    m_tilt = {tilt_upd(ay, m_tilt[3:2]), tilt_upd(ax, m_tilt[1:0])};
                    m_av = 1;
                    blk_x.delete(); blk_y.delete();
                end
            end
            m_sv = 0;
            m_err = 0;
            if (in_frame && frame_abort) begin
                m_err = 1; in_frame = 0; part.delete();
            end else if (byte_valid && frame_start) begin
                if (in_frame) m_err = 1;
                part.delete(); part.push_back(byte_in); in_frame = 1;
            end else if (byte_valid) begin
                if (!in_frame) m_err = 1;
                else begin
                    part.push_back(byte_in);
                    if (part.size() == 6) begin
                        m_raw_x = {part[1], part[0]};
                        m_raw_y = {part[3], part[2]};
                        m_raw_z = {part[5], part[4]};
                        m_sv = 1; m_cnt = m_cnt + 8'd1;
                        in_frame = 0; part.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("raw_x", {16'd0, raw_x}, {16'd0, m_raw_x});
            chk("raw_y", {16'd0, raw_y}, {16'd0, m_raw_y});
            chk("raw_z", {16'd0, raw_z}, {16'd0, m_raw_z});
            chk("sample_valid", {31'd0, sample_valid}, {31'd0, m_sv});
            chk("avg_x", {16'd0, avg_x}, {16'd0, m_avg_x});
            chk("avg_y", {16'd0, avg_y}, {16'd0, m_avg_y});
            chk("avg_valid", {31'd0, avg_valid}, {31'd0, m_av});
            chk("tilt", {28'd0, tilt}, {28'd0, m_tilt});
            chk("frame_error", {31'd0, frame_error}, {31'd0, m_err});
            chk("frame_count", {24'd0, frame_count}, {24'd0, m_cnt});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic bv, input logic fs, input logic fa, input logic [7:0] b);
        byte_valid = bv; frame_start = fs; frame_abort = fa; byte_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                              input int maxgap);
        logic [7:0] b[6];
        b[0] = x[7:0]; b[1] = x[15:8]; b[2] = y[7:0];
        b[3] = y[15:8]; b[4] = z[7:0]; b[5] = z[15:8];
        for (int i = 0; i < 6; i++) begin
            if (i > 0) repeat ($urandom_range(0, maxgap)) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
            cyc(1'b1, i == 0, 1'b0, b[i]);
        end
    endtask

    function automatic logic [15:0] rand_axis();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 240)) - 16'd120;
    endfunction

    task automatic block_of(input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] x2, input logic [15:0] x3);
        send_frame(x0, 16'd0, 16'd0, 1); idle(1);
        send_frame(x1, 16'd0, 16'd0, 1); idle(1);
        send_frame(x2, 16'd0, 16'd0, 1); idle(1);
        send_frame(x3, 16'd0, 16'd0, 1); idle(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(1);
        check_en = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("reset_count", {24'd0, frame_count}, 32'd0);
        chk("reset_raw_x", {16'd0, raw_x}, 32'd0);
        chk("reset_tilt", {28'd0, tilt}, 32'd0);

        // basic frame, checked in the publish cycle
        send_frame(16'h0010, 16'hFFF0, 16'h0100, 0);
        chk("lit_raw_x", {16'd0, raw_x}, 32'h0010);
        chk("lit_raw_y", {16'd0, raw_y}, 32'hFFF0);
        chk("lit_raw_z", {16'd0, raw_z}, 32'h0100);
        chk("lit_sv", {31'd0, sample_valid}, 32'd1);
        chk("lit_count", {24'd0, frame_count}, 32'd1);
        idle(2);

        // averaging and hysteresis
        do_reset();
        block_of(16'd100, 16'd100, 16'd60, 16'd60);
        chk("lit_avg80", {16'd0, avg_x}, 32'd80);
        chk("lit_avg80_valid", {31'd0, avg_valid}, 32'd1);
        chk("lit_right_set", {28'd0, tilt}, 32'b0010);
        block_of(16'd50, 16'd50, 16'd50, 16'd50);
        chk("lit_avg50", {16'd0, avg_x}, 32'd50);
        chk("lit_right_hold", {28'd0, tilt}, 32'b0010);
        block_of(16'd40, 16'd40, 16'd40, 16'd40);
        chk("lit_right_clear", {28'd0, tilt}, 32'b0000);

        do_reset();
        block_of(16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFE);
        chk("lit_avg_floor", {16'd0, avg_x}, 32'hFFFE);
        chk("lit_neg_no_tilt", {28'd0, tilt}, 32'd0);

        // abort after 3 bytes, with a byte in the same cycle
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 8'hAA); cyc(1'b1, 1'b0, 1'b0, 8'hBB); cyc(1'b1, 1'b0, 1'b0, 8'hCC);
        cyc(1'b1, 1'b0, 1'b1, 8'hDD);
        chk("lit_abort_err", {31'd0, frame_error}, 32'd1);
        idle(1);
        send_frame(16'h1234, 16'h5678, 16'h9ABC, 0);
        chk("lit_abort_raw_x", {16'd0, raw_x}, 32'h1234);
        chk("lit_abort_count", {24'd0, frame_count}, 32'd1);
        idle(2);

        // restart on byte 4
        for (int i = 0; i < 4; i++) cyc(1'b1, i == 0, 1'b0, 8'(8'h11 * (i + 1)));
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        chk("lit_restart_err", {31'd0, frame_error}, 32'd1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
        chk("lit_restart_raw_x", {16'd0, raw_x}, 32'h8077);
        chk("lit_restart_raw_z", {16'd0, raw_z}, 32'h8483);
        idle(2);

        // reset during byte 2
        cyc(1'b1, 1'b1, 1'b0, 8'h01); cyc(1'b1, 1'b0, 1'b0, 8'h02);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h03);
        reset = 1'b0;
        chk("lit_rst_count", {24'd0, frame_count}, 32'd0);
        chk("lit_rst_raw_x", {16'd0, raw_x}, 32'd0);
        send_frame(16'hBEEF, 16'h0042, 16'h7FFF, 1);
        chk("lit_rst_frame", {16'd0, raw_x}, 32'hBEEF);
        idle(2);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            int kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                send_frame(rand_axis(), rand_axis(), 16'($urandom), 2);
            end else if (kind == 6) begin
                cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
            end else if (kind == 7) begin
                int k = $urandom_range(1, 5);
                for (int i = 0; i < k; i++) cyc(1'b1, i == 0, 1'b0, 8'($urandom));
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
            end else if (kind == 8) begin
                int k = $urandom_range(1, 5);
                for (int i = 0; i < k; i++) cyc(1'b1, i == 0, 1'b0, 8'($urandom));
                send_frame(rand_axis(), rand_axis(), 16'($urandom), 1);
            end else begin
                cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
            end
            idle($urandom_range(0, 2));
        end
        idle(3);

        // frame counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) send_frame(rand_axis(), rand_axis(), 16'($urandom), 0);
        chk("lit_count_255", {24'd0, frame_count}, 32'd255);
        send_frame(16'd1, 16'd2, 16'd3, 0);
        chk("lit_count_wrap", {24'd0, frame_count}, 32'd0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/accel_frame_assembler.md
Name: accel_frame_assembler

Overview:
- Downstream consumer of the ADXL345 I2C read engine.
- Takes the 6-byte burst read from DATAX0..DATAZ1 (0x32..0x37) one byte at a time and assembles signed 16-bit X/Y/Z samples.
- Block-averages the samples and derives debounced tilt flags (left/right/up/down) for game control and HEX/LED debug display.
- Runs in the I2C byte-clock domain.

Parameters:
- AVG_LOG2, 2, samples per average block = 2^AVG_LOG2 (legal 0..4)
- TILT_THRESH, 64, tilt assert magnitude in LSB (full-res, ~3.9 mg/LSB, so ~0.25 g)
- TILT_HYST, 16, hysteresis in LSB; a flag clears when |avg| < TILT_THRESH - TILT_HYST

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high
- byte_in  input  8  data byte from the I2C reader
- byte_valid  input  1  byte_in is valid this cycle; one byte per asserted cycle
- frame_start  input  1  qualifies byte_valid; marks the byte as DATAX0
- frame_abort  input  1  reader saw NACK or timeout; discard the partial frame
- raw_x, raw_y, raw_z  output  16 each  last complete sample, signed two's complement
- sample_valid  output  1  one-cycle pulse when raw_* update
- avg_x, avg_y  output  16 each  block average, signed
- avg_valid  output  1  one-cycle pulse when avg_* update
- tilt  output  4  {up, down, right, left} (bits 3..0)
- frame_error  output  1  one-cycle pulse on a dropped or malformed frame
- frame_count  output  8  completed frames, wraps 255 -> 0

Behaviour:
- Reset: every output is 0. FSM goes to IDLE, byte index to 0, accumulators and sample counter clear. Reset mid-frame discards the partial frame with no error pulse.
- FSM states:
  - IDLE: waits for byte_valid && frame_start. That byte is stored as index 0 and the FSM moves to COLLECT with index 1. byte_valid without frame_start is ignored and pulses frame_error.
  - COLLECT: each byte_valid stores the byte at the current index, then the index increments. Byte order is X0 X1 Y0 Y1 Z0 Z1, LSB first per axis. Accepting index 5 moves the FSM to PUBLISH.
  - PUBLISH (one cycle): raw_* = {hi, lo}, sample_valid = 1, frame_count += 1, sample fed to the averager. Returns to IDLE. byte_valid in this cycle is treated as in IDLE.
- Latency: sample_valid is asserted exactly 1 clock after the cycle that accepted Z1.
- byte_valid && frame_start while in COLLECT: pulse frame_error, discard the partial frame, store this byte as index 0, index becomes 1.
- frame_abort while in COLLECT: pulse frame_error and return to IDLE. frame_abort wins over a byte_valid in the same cycle. frame_abort in IDLE or PUBLISH is ignored; PUBLISH still completes.
- Averaging (block, not moving):
  - Signed accumulators for X and Y, each 16+AVG_LOG2 bits. The Z average is not required.
  - Each published sample is added. On the 2^AVG_LOG2-th sample: avg = sum >>> AVG_LOG2 (arithmetic shift, i.e. floor), avg_valid pulses 1 clock after sample_valid, and the accumulators reload to 0.
  - AVG_LOG2 = 0 passes samples straight through with the same 1-clock delay.
- Tilt, evaluated only in the avg_valid cycle, based on the new avg:
  - right set if avg_x > TILT_THRESH; left set if avg_x < -TILT_THRESH.
  - A set flag clears when |avg_x| < TILT_THRESH - TILT_HYST; otherwise it holds.
  - left and right are never both 1: a sign flip beyond the threshold switches directly.
  - up/down follow the same rules using avg_y (up = positive).
  - Comparisons are signed at 16+2 bits to avoid overflow at -32768.

Decomposition:
- Shared package accel_pkg:
  - ACCEL_FRAME_BYTES = 6
  - register addresses 0x32..0x37
  - TILT_LEFT/RIGHT/DOWN/UP bit indices 0..3
  - FSM state encoding (IDLE, COLLECT, PUBLISH)
- One sub-module: axis_block_avg (accumulator + sample counter + shift + hysteresis comparator), instantiated for X and Y.
- Frame FSM stays in the top module.

Test Plan:
- Frame 0x10,0x00, 0xF0,0xFF, 0x00,0x01 with frame_start on the first byte -> 1 clock after Z1: raw_x=0x0010, raw_y=0xFFF0 (-16), raw_z=0x0100; sample_valid pulses once; frame_count=1.
- Four frames, AVG_LOG2=2, X = 100, 100, 60, 60 -> avg_x=80, avg_valid on the 4th sample only, tilt[1] (right)=1. Then four frames of X=50 -> avg_x=50 (≥48), right stays 1. Then four of X=40 -> right clears.
- Four frames of X=-1, -2, -2, -2 -> avg_x=-2 (floor of -1.75), no tilt.
- Abort after 3 bytes, then a full frame -> frame_error pulses once, raw_* reflect only the full frame, frame_count +1.
- frame_start mid-frame at byte 4 -> frame_error pulse; the following 5 bytes complete a new frame made of the restart byte plus those 5.
- Reset asserted during byte 2 -> all outputs 0 and the next full frame assembles correctly. Also run 256 frames -> frame_count wraps to 0.
